multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control unit for the MIPS datapath. A Moore-style state machine with Mealy qualification on memory ready, sequencing each instruction through fetch, decode, execute, memory and write-back. It adds BEQ/BNE and a memory wait-state handshake with timeout, and traps illegal opcodes. It sits between the instruction register (opcode source) and the shared instruction/data memory, ALU, register file and PC muxes.

## Interface
- ALU_OP_WIDTH, 3: width of alu_op_o; ≥3; codes below are zero-extended.
- WAIT_TIMEOUT, 15: maximum consecutive not-ready cycles in a memory state before trapping; 0 disables the timeout.

- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode_i  in  6  instr[31:26] from the IR.
- mem_ready_i  in  1  memory completes the current read/write this cycle.
- pc_write_o  out  1  unconditional PC load.
- pc_write_eq_o / pc_write_ne_o  out  1 each  conditional PC load on ALU zero / not-zero.
- pc_src_o  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump address.
- iord_o  out  1  0 = PC address, 1 = ALUOut address.
- mem_read_o / mem_write_o  out  1 each  memory strobes.
- ir_write_o  out  1  IR load.
- reg_dst_o  out  1  1 = rd, 0 = rt.
- mem_to_reg_o  out  1  write-back source is MDR.
- reg_write_o  out  1  register-file write.
- alu_src_a_o  out  1  0 = PC, 1 = register A.
- alu_src_b_o  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
- alu_op_o  out  ALU_OP_WIDTH  ALU operation code: 100 add, 001 lui, 010 or, 011 and, 101 mem-add, 110 sub, 111 R-type funct.
- instr_done_o  out  1  one-cycle pulse in the final state of each instruction.
- error_o  out  1  sticky trap flag.
- state_o  out  4  current state encoding.

## Operation
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC_R 7, R_WB 8, EXEC_I 9, I_WB 10, BRANCH 11, JUMP 12, ERROR 15.
- Any output not listed for a state is 0.
- IDLE: all outputs 0. Goes to FETCH on the first clock after reset is released.
- FETCH: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 100.
  - When mem_ready_i = 1: ir_write = 1 and pc_write = 1, both combinational on ready; next state is DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 100. opcode_i is latched into an internal register that drives all later states. Next state by opcode:
  - 0x23 (LW) or 0x2b (SW) → MEM_ADDR.
  - 0x00 → EXEC_R.
  - 0x08, 0x0f, 0x0d, 0x0c → EXEC_I.
  - 0x04 (BEQ) or 0x05 (BNE) → BRANCH.
  - 0x02 → JUMP.
  - Any other opcode → ERROR.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 101. Next state is MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read = 1, iord = 1. Goes to MEM_WB on ready.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0, done = 1. Goes to FETCH.
- MEM_WR: mem_write = 1, iord = 1. On ready: done = 1 and next state is FETCH.
- EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 111. Goes to R_WB.
- R_WB: reg_write = 1, reg_dst = 1, done = 1. Goes to FETCH.
- EXEC_I: alu_src_a = 1, alu_src_b = 10, alu_op = ADDI 100 / LUI 001 / ORI 010 / ANDI 011. Goes to I_WB.
- I_WB: reg_write = 1, reg_dst = 0, done = 1. Goes to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 110, pc_src = 01. pc_write_eq = 1 for BEQ, pc_write_ne = 1 for BNE, done = 1. Goes to FETCH.
- JUMP: pc_write = 1, pc_src = 10, done = 1. Goes to FETCH.
- ERROR: error_o = 1, all other outputs 0. Held until reset.

## Timing
- Reset: asynchronous. State becomes IDLE immediately and every output is 0, including error_o.
- Reset mid-instruction aborts the instruction; no strobe is asserted after reset rises.
- Instruction latency in cycles with zero memory wait:
  - LW: 5.
  - SW, R-type, I-type: 4.
  - BEQ, BNE, J: 3.
- Each not-ready cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- Wait counter:
  - Cleared on entry to each memory state.
  - Increments on every cycle in that state with mem_ready_i = 0.
  - If mem_ready_i = 0 while the counter equals WAIT_TIMEOUT − 1, the next state is ERROR.
  - If mem_ready_i = 1 in that same cycle, completion wins.
- Strobes stay asserted during wait cycles. ir_write, pc_write in FETCH, and the MEM_WR done pulse occur only in the ready cycle.
- The counter must not wrap; width is clog2(WAIT_TIMEOUT + 1).
- opcode_i changes after DECODE have no effect.

## Test plan
- Reset pulse mid-LW (state 4) → state_o = 0 and all outputs 0 asynchronously. After release, state_o = 1 on the next edge.
- LW (0x23) with ready held at 1 → state sequence 1, 2, 3, 4, 5, 1. reg_write and mem_to_reg = 1 in state 5. instr_done pulses exactly once.
- BEQ (0x04) then BNE (0x05) → state sequence 1, 2, 11. In state 11: pc_write_eq = 1 and pc_write_ne = 0 for BEQ, then swapped for BNE; pc_src = 01 and alu_op = 110 in both.
- ADDI, LUI, ORI, ANDI → alu_op in state 9 is 100, 001, 010, 011 respectively, and reg_dst = 0 in state 10. Toggle opcode_i during state 9 → alu_op unchanged.
- FETCH with ready low for 3 cycles, WAIT_TIMEOUT = 4 → stays in state 1, mem_read = 1, ir_write = 0. Ready high on the 4th cycle → ir_write = pc_write = 1 and next state is 2.
- Ready low for 4 cycles in MEM_WR with WAIT_TIMEOUT = 4 → state_o = 15 and error_o = 1, held. Opcode 0x3f in DECODE → ERROR.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and the datapath:
// opcode/memory-ready in, every datapath select and strobe out.
interface multicycle_control_if #(
  parameter int ALU_OP_WIDTH = 3
);
  logic [5:0]              opcode_i;
  logic                    mem_ready_i;
  logic                    pc_write_o;
  logic                    pc_write_eq_o;
  logic                    pc_write_ne_o;
  logic [1:0]              pc_src_o;
  logic                    iord_o;
  logic                    mem_read_o;
  logic                    mem_write_o;
  logic                    ir_write_o;
  logic                    reg_dst_o;
  logic                    mem_to_reg_o;
  logic                    reg_write_o;
  logic                    alu_src_a_o;
  logic [1:0]              alu_src_b_o;
  logic [ALU_OP_WIDTH-1:0] alu_op_o;
  logic                    instr_done_o;
  logic                    error_o;
  logic [3:0]              state_o;

  modport master (
    input  opcode_i, mem_ready_i,
    output pc_write_o, pc_write_eq_o, pc_write_ne_o, pc_src_o, iord_o,
           mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
           reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, instr_done_o,
           error_o, state_o
  );

  modport slave (
    output opcode_i, mem_ready_i,
    input  pc_write_o, pc_write_eq_o, pc_write_ne_o, pc_src_o, iord_o,
           mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
           reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, instr_done_o,
           error_o, state_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory wait-state handshake, timeout trap
// and illegal-opcode trap. Outputs are registered from the next state; only
// the ready-qualified strobes (FETCH ir/pc write, MEM_WR done) are combinational.
//
// state    | meaning
// IDLE     | 0  post-reset, all outputs low
// FETCH    | 1  read instruction, PC+4; load IR/PC on ready
// DECODE   | 2  latch opcode, compute branch target
// MEM_ADDR | 3  effective address for LW/SW
// MEM_RD   | 4  data read, wait for ready
// MEM_WB   | 5  write MDR to rt
// MEM_WR   | 6  data write, wait for ready
// EXEC_R   | 7  R-type ALU op
// R_WB     | 8  write ALUOut to rd
// EXEC_I   | 9  immediate ALU op
// I_WB     | 10 write ALUOut to rt
// BRANCH   | 11 BEQ/BNE compare and conditional PC load
// JUMP     | 12 jump PC load
// ERROR    | 15 trap, held until reset
module multicycle_control #(
  parameter int ALU_OP_WIDTH = 3,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

  localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_ERROR    = 4'd15
  } state_t;

  typedef struct packed {
    logic                    pc_write;
    logic                    pc_write_eq;
    logic                    pc_write_ne;
    logic [1:0]              pc_src;
    logic                    iord;
    logic                    mem_read;
    logic                    mem_write;
    logic                    reg_dst;
    logic                    mem_to_reg;
    logic                    reg_write;
    logic                    alu_src_a;
    logic [1:0]              alu_src_b;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic                    done;
    logic                    error;
  } ctrl_t;

  state_t           state, state_nxt;
  logic [5:0]       opcode_q, op_eff;
  logic [CNT_W-1:0] wait_cnt;
  logic             ready, timeout, fetch_ready;
  ctrl_t            ctrl_q, ctrl_nxt;

  assign ready = bus.mem_ready_i;

  always_comb begin
    // DECODE still sees the live opcode; afterwards only the latched copy counts
    op_eff  = (state == S_DECODE) ? bus.opcode_i : opcode_q;
    timeout = (WAIT_TIMEOUT != 0) && !ready && (int'(wait_cnt) == WAIT_TIMEOUT - 1);

    state_nxt = state;
    unique case (state)
      S_IDLE:     state_nxt = S_FETCH;
      S_FETCH:    state_nxt = ready ? S_DECODE : (timeout ? S_ERROR : S_FETCH);
      S_DECODE: begin
        case (bus.opcode_i)
          6'h23, 6'h2b:               state_nxt = S_MEM_ADDR;
          6'h00:                      state_nxt = S_EXEC_R;
          6'h08, 6'h0f, 6'h0d, 6'h0c: state_nxt = S_EXEC_I;
          6'h04, 6'h05:               state_nxt = S_BRANCH;
          6'h02:                      state_nxt = S_JUMP;
          default:                    state_nxt = S_ERROR;
        endcase
      end
      S_MEM_ADDR: state_nxt = (opcode_q == 6'h23) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_nxt = ready ? S_MEM_WB : (timeout ? S_ERROR : S_MEM_RD);
      S_MEM_WB:   state_nxt = S_FETCH;
      S_MEM_WR:   state_nxt = ready ? S_FETCH : (timeout ? S_ERROR : S_MEM_WR);
      S_EXEC_R:   state_nxt = S_R_WB;
      S_R_WB:     state_nxt = S_FETCH;
      S_EXEC_I:   state_nxt = S_I_WB;
      S_I_WB:     state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_JUMP:     state_nxt = S_FETCH;
      S_ERROR:    state_nxt = S_ERROR;
      default:    state_nxt = S_ERROR;
    endcase

    ctrl_nxt = '0;
    case (state_nxt)
      S_FETCH: begin
        ctrl_nxt.mem_read  = 1'b1;
        ctrl_nxt.alu_src_b = 2'b01;
        ctrl_nxt.alu_op    = ALU_OP_WIDTH'(3'b100);
      end
      S_DECODE: begin
        ctrl_nxt.alu_src_b = 2'b11;
        ctrl_nxt.alu_op    = ALU_OP_WIDTH'(3'b100);
      end
      S_MEM_ADDR: begin
        ctrl_nxt.alu_src_a = 1'b1;
        ctrl_nxt.alu_src_b = 2'b10;
        ctrl_nxt.alu_op    = ALU_OP_WIDTH'(3'b101);
      end
      S_MEM_RD: begin
        ctrl_nxt.mem_read = 1'b1;
        ctrl_nxt.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_nxt.reg_write  = 1'b1;
        ctrl_nxt.mem_to_reg = 1'b1;
        ctrl_nxt.done       = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_nxt.mem_write = 1'b1;
        ctrl_nxt.iord      = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_nxt.alu_src_a = 1'b1;
        ctrl_nxt.alu_op    = ALU_OP_WIDTH'(3'b111);
      end
      S_R_WB: begin
        ctrl_nxt.reg_write = 1'b1;
        ctrl_nxt.reg_dst   = 1'b1;
        ctrl_nxt.done      = 1'b1;
      end
      S_EXEC_I: begin
        ctrl_nxt.alu_src_a = 1'b1;
        ctrl_nxt.alu_src_b = 2'b10;
        case (op_eff)
          6'h0f:   ctrl_nxt.alu_op = ALU_OP_WIDTH'(3'b001);
          6'h0d:   ctrl_nxt.alu_op = ALU_OP_WIDTH'(3'b010);
          6'h0c:   ctrl_nxt.alu_op = ALU_OP_WIDTH'(3'b011);
          default: ctrl_nxt.alu_op = ALU_OP_WIDTH'(3'b100);
        endcase
      end
      S_I_WB: begin
        ctrl_nxt.reg_write = 1'b1;
        ctrl_nxt.done      = 1'b1;
      end
      S_BRANCH: begin
        ctrl_nxt.alu_src_a   = 1'b1;
        ctrl_nxt.alu_op      = ALU_OP_WIDTH'(3'b110);
        ctrl_nxt.pc_src      = 2'b01;
        ctrl_nxt.pc_write_eq = (op_eff == 6'h04);
        ctrl_nxt.pc_write_ne = (op_eff == 6'h05);
        ctrl_nxt.done        = 1'b1;
      end
      S_JUMP: begin
        ctrl_nxt.pc_write = 1'b1;
        ctrl_nxt.pc_src   = 2'b10;
        ctrl_nxt.done     = 1'b1;
      end
      S_ERROR:  ctrl_nxt.error = 1'b1;
      default:  ctrl_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      opcode_q <= '0;
      wait_cnt <= '0;
      ctrl_q   <= '0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= ctrl_nxt;
      if (state == S_DECODE)
        opcode_q <= bus.opcode_i;
      // Any state change restarts the count, so each memory state starts at 0
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (!ready && (wait_cnt != {CNT_W{1'b1}}))
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign fetch_ready = (state == S_FETCH) && ready;

  assign bus.pc_write_o    = ctrl_q.pc_write | fetch_ready;
  assign bus.pc_write_eq_o = ctrl_q.pc_write_eq;
  assign bus.pc_write_ne_o = ctrl_q.pc_write_ne;
  assign bus.pc_src_o      = ctrl_q.pc_src;
  assign bus.iord_o        = ctrl_q.iord;
  assign bus.mem_read_o    = ctrl_q.mem_read;
  assign bus.mem_write_o   = ctrl_q.mem_write;
  assign bus.ir_write_o    = fetch_ready;
  assign bus.reg_dst_o     = ctrl_q.reg_dst;
  assign bus.mem_to_reg_o  = ctrl_q.mem_to_reg;
  assign bus.reg_write_o   = ctrl_q.reg_write;
  assign bus.alu_src_a_o   = ctrl_q.alu_src_a;
  assign bus.alu_src_b_o   = ctrl_q.alu_src_b;
  assign bus.alu_op_o      = ctrl_q.alu_op;
  assign bus.instr_done_o  = ctrl_q.done | ((state == S_MEM_WR) && ready);
  assign bus.error_o       = ctrl_q.error;
  assign bus.state_o       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each scenario queues expected
// per-cycle state/control words, then drains the queue against the DUT.
module tb_multicycle_control;

  localparam int WT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic        rdy;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [19:0] ctl;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] cur_op = 6'h00;

  multicycle_control_if #(.ALU_OP_WIDTH(3)) bus ();

  multicycle_control #(.ALU_OP_WIDTH(3), .WAIT_TIMEOUT(WT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected control word straight from the per-state output table
  function automatic logic [19:0] model(input logic [3:0] st, input logic [5:0] op, input logic rdy);
    logic pcw, eq, ne, iord, mr, mw, irw, rd, m2r, rw, aa, done, err;
    logic [1:0] psrc, ab;
    logic [2:0] aop;
    pcw = 0; eq = 0; ne = 0; iord = 0; mr = 0; mw = 0; irw = 0; rd = 0;
    m2r = 0; rw = 0; aa = 0; done = 0; err = 0; psrc = 2'b00; ab = 2'b00; aop = 3'b000;
    case (st)
      4'd1:  begin mr = 1; ab = 2'b01; aop = 3'b100; irw = rdy; pcw = rdy; end
      4'd2:  begin ab = 2'b11; aop = 3'b100; end
      4'd3:  begin aa = 1; ab = 2'b10; aop = 3'b101; end
      4'd4:  begin mr = 1; iord = 1; end
      4'd5:  begin rw = 1; m2r = 1; done = 1; end
      4'd6:  begin mw = 1; iord = 1; done = rdy; end
      4'd7:  begin aa = 1; ab = 2'b00; aop = 3'b111; end
      4'd8:  begin rw = 1; rd = 1; done = 1; end
      4'd9: begin
        aa = 1; ab = 2'b10;
        case (op)
          6'h08: aop = 3'b100;
          6'h0f: aop = 3'b001;
          6'h0d: aop = 3'b010;
          6'h0c: aop = 3'b011;
          default: aop = 3'bxxx;
        endcase
      end
      4'd10: begin rw = 1; done = 1; end
      4'd11: begin aa = 1; aop = 3'b110; psrc = 2'b01; eq = (op == 6'h04); ne = (op == 6'h05); done = 1; end
      4'd12: begin pcw = 1; psrc = 2'b10; done = 1; end
      4'd15: err = 1;
      default: ;
    endcase
    return {pcw, eq, ne, psrc, iord, mr, mw, irw, rd, m2r, rw, aa, ab, aop, done, err};
  endfunction

  function automatic logic [19:0] observed();
    return {bus.pc_write_o, bus.pc_write_eq_o, bus.pc_write_ne_o, bus.pc_src_o, bus.iord_o,
            bus.mem_read_o, bus.mem_write_o, bus.ir_write_o, bus.reg_dst_o, bus.mem_to_reg_o,
            bus.reg_write_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o,
            bus.instr_done_o, bus.error_o};
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rdy, input logic [5:0] op, input logic [3:0] st);
    exp_t e;
    e.rdy = rdy; e.op = op; e.st = st; e.ctl = model(st, cur_op, rdy);
    exp_q.push_back(e);
  endtask

  // Queue the expected cycles of one instruction, FETCH through its last state.
  // opcode_i is randomised outside DECODE to show it is ignored there.
  task automatic push_instr(input logic [5:0] op, input int fw, input int mw);
    cur_op = op;
    for (int i = 0; i < fw; i++) push(1'b0, rnd_op(), 4'd1);
    push(1'b1, rnd_op(), 4'd1);
    push(rnd_bit(), op, 4'd2);
    case (op)
      6'h23: begin
        push(rnd_bit(), rnd_op(), 4'd3);
        for (int i = 0; i < mw; i++) push(1'b0, rnd_op(), 4'd4);
        push(1'b1, rnd_op(), 4'd4);
        push(rnd_bit(), rnd_op(), 4'd5);
      end
      6'h2b: begin
        push(rnd_bit(), rnd_op(), 4'd3);
        for (int i = 0; i < mw; i++) push(1'b0, rnd_op(), 4'd6);
        push(1'b1, rnd_op(), 4'd6);
      end
      6'h00: begin push(rnd_bit(), rnd_op(), 4'd7); push(rnd_bit(), rnd_op(), 4'd8); end
      6'h08, 6'h0f, 6'h0d, 6'h0c: begin
        push(rnd_bit(), rnd_op(), 4'd9); push(rnd_bit(), rnd_op(), 4'd10);
      end
      6'h04, 6'h05: push(rnd_bit(), rnd_op(), 4'd11);
      6'h02:        push(rnd_bit(), rnd_op(), 4'd12);
      default:      push(rnd_bit(), rnd_op(), 4'd15);
    endcase
  endtask

  task automatic push_tail();
    push(1'b0, rnd_op(), 4'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_ready_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    push(rnd_bit(), rnd_op(), 4'd0);
  endtask

  // Drive one queued cycle, sample at the falling edge, then step past the rising edge
  task automatic cycle_pop(output exp_t e, output logic [3:0] st, output logic [19:0] ctl);
    e = exp_q.pop_front();
    bus.mem_ready_i = e.rdy;
    bus.opcode_i    = e.op;
    @(negedge clk);
    st  = bus.state_o;
    ctl = observed();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e; logic [3:0] s; logic [19:0] c;
    @(posedge clk); #1;
    checks++;
    if ({bus.state_o, observed()} !== 24'h0) begin
      errors++; $display("FAIL reset_init state got %0d ctl got %b exp 0", bus.state_o, observed());
    end
    do_reset();
    cur_op = 6'h23;
    push(1'b1, rnd_op(), 4'd1);
    push(1'b1, 6'h23, 4'd2);
    push(1'b1, rnd_op(), 4'd3);
    push(1'b0, rnd_op(), 4'd4);
    push(1'b0, rnd_op(), 4'd4);
    while (exp_q.size() > 0) begin
      cycle_pop(e, s, c);
      checks++;
      if ({s, c} !== {e.st, e.ctl}) begin
        errors++; $display("FAIL reset_pre state got %0d exp %0d ctl got %b exp %b", s, e.st, c, e.ctl);
      end
    end
    bus.mem_ready_i = 1'b0;
    #2;
    checks++;
    if (bus.state_o !== 4'd4 || bus.mem_read_o !== 1'b1) begin
      errors++; $display("FAIL mid_lw state got %0d exp 4 mem_read got %b exp 1", bus.state_o, bus.mem_read_o);
    end
    reset = 1'b1;
    bus.mem_ready_i = 1'b1;
    #1;
    checks++;
    if ({bus.state_o, observed()} !== 24'h0) begin
      errors++; $display("FAIL async_reset state got %0d ctl got %b exp 0", bus.state_o, observed());
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.state_o, observed()} !== 24'h0) begin
      errors++; $display("FAIL reset_held state got %0d ctl got %b exp 0", bus.state_o, observed());
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.state_o, observed()} !== {4'd1, model(4'd1, 6'h00, 1'b1)}) begin
      errors++; $display("FAIL reset_release state got %0d exp 1 ctl got %b exp %b",
                         bus.state_o, observed(), model(4'd1, 6'h00, 1'b1));
    end
  endtask

  task automatic test_lw();
    exp_t e; logic [3:0] s; logic [19:0] c;
    do_reset();
    push_instr(6'h23, 0, 0);
    push_instr(6'h23, 0, 3);
    push_tail();
    while (exp_q.size() > 0) begin
      cycle_pop(e, s, c);
      checks++;
      if ({s, c} !== {e.st, e.ctl}) begin
        errors++; $display("FAIL lw state got %0d exp %0d ctl got %b exp %b", s, e.st, c, e.ctl);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e; logic [3:0] s; logic [19:0] c;
    do_reset();
    push_instr(6'h04, 0, 0);
    push_instr(6'h05, 0, 0);
    push_tail();
    while (exp_q.size() > 0) begin
      cycle_pop(e, s, c);
      checks++;
      if ({s, c} !== {e.st, e.ctl}) begin
        errors++; $display("FAIL branch state got %0d exp %0d ctl got %b exp %b", s, e.st, c, e.ctl);
      end
    end
  endtask

  task automatic test_itype();
    exp_t e; logic [3:0] s; logic [19:0] c;
    do_reset();
    push_instr(6'h08, 0, 0);
    push_instr(6'h0f, 0, 0);
    push_instr(6'h0d, 0, 0);
    push_instr(6'h0c, 0, 0);
    push_tail();
    while (exp_q.size() > 0) begin
      cycle_pop(e, s, c);
      checks++;
      if ({s, c} !== {e.st, e.ctl}) begin
        errors++; $display("FAIL itype state got %0d exp %0d ctl got %b exp %b", s, e.st, c, e.ctl);
      end
    end
  endtask

  task automatic test_fetch_wait();
    exp_t e; logic [3:0] s; logic [19:0] c;
    do_reset();
    push_instr(6'h0d, WT - 1, 0);
    push_instr(6'h2b, 2, WT - 1);
    push_tail();
    while (exp_q.size() > 0) begin
      cycle_pop(e, s, c);
      checks++;
      if ({s, c} !== {e.st, e.ctl}) begin
        errors++; $display("FAIL fetch_wait state got %0d exp %0d ctl got %b exp %b", s, e.st, c, e.ctl);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e; logic [3:0] s; logic [19:0] c;
    do_reset();
    cur_op = 6'h2b;
    push(1'b1, rnd_op(), 4'd1);
    push(rnd_bit(), 6'h2b, 4'd2);
    push(rnd_bit(), rnd_op(), 4'd3);
    for (int i = 0; i < WT; i++) push(1'b0, rnd_op(), 4'd6);
    for (int i = 0; i < 3; i++) push(rnd_bit(), rnd_op(), 4'd15);
    while (exp_q.size() > 0) begin
      cycle_pop(e, s, c);
      checks++;
      if ({s, c} !== {e.st, e.ctl}) begin
        errors++; $display("FAIL timeout state got %0d exp %0d ctl got %b exp %b", s, e.st, c, e.ctl);
      end
    end
  endtask

  task automatic test_illegal();
    exp_t e; logic [3:0] s; logic [19:0] c;
    do_reset();
    push_instr(6'h3f, 0, 0);
    for (int i = 0; i < 3; i++) push(rnd_bit(), rnd_op(), 4'd15);
    while (exp_q.size() > 0) begin
      cycle_pop(e, s, c);
      checks++;
      if ({s, c} !== {e.st, e.ctl}) begin
        errors++; $display("FAIL illegal state got %0d exp %0d ctl got %b exp %b", s, e.st, c, e.ctl);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [3:0] s; logic [19:0] c;
    do_reset();
    push_instr(6'h00, 0, 0);
    push_instr(6'h08, 1, 0);
    push_instr(6'h02, 0, 0);
    push_instr(6'h05, 0, 0);
    push_instr(6'h2b, 0, 2);
    push_instr(6'h23, 2, 1);
    push_instr(6'h04, 0, 0);
    push_instr(6'h00, 0, 0);
    push_tail();
    while (exp_q.size() > 0) begin
      cycle_pop(e, s, c);
      checks++;
      if ({s, c} !== {e.st, e.ctl}) begin
        errors++; $display("FAIL back_to_back state got %0d exp %0d ctl got %b exp %b", s, e.st, c, e.ctl);
      end
    end
  endtask

  initial begin
    bus.opcode_i    = 6'h00;
    bus.mem_ready_i = 1'b0;
    test_reset();
    test_lw();
    test_branch();
    test_itype();
    test_fetch_wait();
    test_timeout();
    test_illegal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
